// File: rtl/cook_pkg.sv
// cook_pkg: shared state codes, BCD digit type and countdown constants for the cook sequencer
package cook_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COOKING = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  function automatic bcd_t bcd_dec(input bcd_t d, input bcd_t wrap);
    return (d == 4'd0) ? wrap : d - 4'd1;
  endfunction
endpackage

// File: rtl/bcd_time_reg.sv
// bcd_time_reg: MM:SS digit register with keypad shift-in, clear and borrow-chain decrement
module bcd_time_reg
  import cook_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic clr,
  input  logic shift,
  input  bcd_t digit,
  input  logic dec,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic is_zero,
  output logic is_one
);
  logic b_so, b_st, b_mo;
  // borrow ripples left only while every lower digit is zero
  always_comb begin
    b_so = sec_ones == 4'd0;
    b_st = b_so & (sec_tens == 4'd0);
    b_mo = b_st & (min_ones == 4'd0);
    is_zero = b_mo & (min_tens == 4'd0);
    is_one = (sec_ones == 4'd1) & ({min_tens, min_ones, sec_tens} == 12'd0);
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (clr) begin
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
    end else if (shift) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit;
    end else if (dec) begin
      sec_ones <= bcd_dec(sec_ones, BCD_MAX);
      if (b_so) sec_tens <= bcd_dec(sec_tens, SEC_TENS_MAX);
      if (b_st) min_ones <= bcd_dec(min_ones, BCD_MAX);
      if (b_mo) min_tens <= bcd_dec(min_tens, BCD_MAX);
    end
endmodule

// File: rtl/cook_sequencer.sv
// cook_sequencer: microwave magnetron sequencer - keypad entry, countdown, door/stop interlocks, beep
module cook_sequencer
  import cook_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int BEEP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       timer_done,
  output logic       beep
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [1:0] st, nxt;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  logic start_q1, start_q2, stop_q1, stop_q2;
  logic start_ev, stop_ev, tick, clr, shift, dec, done_set, is_zero, is_one;
  assign start_ev = start_q2 & ~start_q1;
  assign stop_ev = stop_q2 & ~stop_q1;
  assign tick = (st == COOKING) & (presc == PW'(TICK_DIV - 1));
  assign shift = (st == IDLE) & key_valid & (key_digit <= BCD_MAX) & ~stop_ev;
  // door gate is combinational so the magnetron drops in the very cycle the door opens
  assign mag_on = (st == COOKING) & door_closed;
  assign beep = st == DONE;
  always_comb begin
    nxt = st;
    clr = 1'b0;
    dec = 1'b0;
    done_set = 1'b0;
    case (st)
      IDLE:
        if (stop_ev) clr = 1'b1;
        else if (start_ev & door_closed & ~is_zero) nxt = COOKING;
      COOKING:
        if (~door_closed | stop_ev) nxt = PAUSED;
        else if (tick) begin
          dec = 1'b1;
          nxt = is_one ? DONE : COOKING;
          done_set = is_one;
        end
      PAUSED:
        if (stop_ev) begin
          clr = 1'b1;
          nxt = IDLE;
        end else if (start_ev & door_closed) nxt = COOKING;
      default:
        nxt = (stop_ev | (bcnt == BW'(BEEP_CYCLES - 1))) ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      st <= IDLE;
      presc <= '0;
      bcnt <= '0;
      timer_done <= 1'b0;
      start_q1 <= 1'b1;
      start_q2 <= 1'b1;
      stop_q1 <= 1'b1;
      stop_q2 <= 1'b1;
    end else begin
      st <= nxt;
      presc <= (st == COOKING && !tick) ? presc + 1'b1 : '0;
      bcnt <= (st == DONE) ? bcnt + 1'b1 : '0;
      timer_done <= done_set;
      start_q1 <= startn;
      start_q2 <= start_q1;
      stop_q1 <= stopn;
      stop_q2 <= stop_q1;
    end
  bcd_time_reg u_time (
    .clk(clk),
    .clrn(clrn),
    .clr(clr),
    .shift(shift),
    .digit(key_digit),
    .dec(dec),
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .is_zero(is_zero),
    .is_one(is_one)
  );
endmodule
